// File: rtl/dsp_fe_pkg.sv
// Shared types, sizes and pattern helpers for the DSP frontend transmit path.
package dsp_fe_pkg;

    localparam int unsigned LANE_WIDTH    = 16;
    localparam int unsigned ADC_WIDTH     = 6;
    localparam int unsigned DES_WIDTH     = 2;
    localparam int unsigned FRAME_SAMPLES = LANE_WIDTH * DES_WIDTH;
    localparam int unsigned FRAME_BITS    = FRAME_SAMPLES * ADC_WIDTH;
    localparam int unsigned FIFO_DEPTH    = 4;
    localparam int unsigned LFSR_WIDTH    = 7;
    localparam logic [ADC_WIDTH-1:0] IDLE_CODE = 6'h20;

    typedef enum logic [1:0] {
        TX_FIFO  = 2'd0,
        TX_RAMP  = 2'd1,
        TX_PRBS7 = 2'd2,
        TX_CONST = 2'd3
    } tx_mode_e;

    typedef logic [FRAME_SAMPLES-1:0][ADC_WIDTH-1:0]           frame_t;
    typedef logic [LANE_WIDTH-1:0][ADC_WIDTH-1:0][DES_WIDTH-1:0] lad_t;

    typedef struct packed {
        logic [LFSR_WIDTH-1:0] state;
        frame_t                bits;
    } prbs_step_t;

    // One frame of PRBS7 (x^7+x^6+1): serial bit k lands at flat frame bit k.
    function automatic prbs_step_t prbs7_step(input logic [LFSR_WIDTH-1:0] seed);
        prbs_step_t            r;
        logic [LFSR_WIDTH-1:0] s;
        logic [FRAME_BITS-1:0] b;
        s = seed;
        for (int unsigned k = 0; k < FRAME_BITS; k++) begin
            b[k] = s[6];
            s    = {s[5:0], s[6] ^ s[5]};
        end
        r.state = s;
        r.bits  = frame_t'(b);
        return r;
    endfunction

    function automatic lad_t to_lad(input frame_t f);
        lad_t r;
        for (int unsigned l = 0; l < LANE_WIDTH; l++)
            for (int unsigned d = 0; d < DES_WIDTH; d++)
                for (int unsigned a = 0; a < ADC_WIDTH; a++)
                    r[l][a][d] = f[l + LANE_WIDTH * d][a];
        return r;
    endfunction

    function automatic frame_t fill_frame(input logic [ADC_WIDTH-1:0] v);
        frame_t f;
        for (int unsigned t = 0; t < FRAME_SAMPLES; t++)
            f[t] = v;
        return f;
    endfunction

    function automatic frame_t ramp_frame(input logic [ADC_WIDTH-1:0] base);
        frame_t f;
        for (int unsigned t = 0; t < FRAME_SAMPLES; t++)
            f[t] = base + ADC_WIDTH'(t);
        return f;
    endfunction

endpackage

// File: rtl/dsp_fe_frame_fifo.sv
// Synchronous frame FIFO; pointers carry one extra wrap bit for full/empty.
module dsp_fe_frame_fifo
    import dsp_fe_pkg::*;
#(
    parameter int unsigned DEPTH = FIFO_DEPTH
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_push,
    input  logic [FRAME_BITS-1:0] i_wdata,
    input  logic                  i_pop,
    output logic [FRAME_BITS-1:0] o_rdata,
    output logic                  o_full,
    output logic                  o_empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [FRAME_BITS-1:0] r_mem [DEPTH];
    logic [AW:0]           r_wptr;
    logic [AW:0]           r_rptr;
    logic                  w_wr;
    logic                  w_rd;

    assign o_empty = (r_wptr == r_rptr);
    assign o_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign o_rdata = r_mem[r_rptr[AW-1:0]];
    assign w_wr    = i_push && !o_full;
    assign w_rd    = i_pop && !o_empty;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_wr) r_wptr <= r_wptr + (AW+1)'(1);
            if (w_rd) r_rptr <= r_rptr + (AW+1)'(1);
        end
    end

    // Storage needs no reset; stale entries are never visible past the pointers.
    always_ff @(posedge i_clk) begin
        if (w_wr && !i_rst) r_mem[r_wptr[AW-1:0]] <= i_wdata;
    end

endmodule

// File: rtl/dsp_fe_lad_tx.sv
// Transmit frontend: buffers time-ordered frames or generates patterns and
// emits them every cycle in lane/adc/des order.
module dsp_fe_lad_tx
    import dsp_fe_pkg::*;
(
    input  logic                                            i_clk,
    input  logic                                            i_rst,
    input  logic [FRAME_SAMPLES-1:0][ADC_WIDTH-1:0]         i_dat,
    input  logic                                            i_vld,
    output logic                                            o_rdy,
    input  logic                                            i_en,
    input  logic [1:0]                                      i_mode,
    input  logic [ADC_WIDTH-1:0]                            i_const,
    output logic [LANE_WIDTH-1:0][ADC_WIDTH-1:0][DES_WIDTH-1:0] o_dat_lad,
    output logic                                            o_vld,
    output logic                                            o_underflow,
    output logic [15:0]                                     o_underflow_cnt,
    output logic [15:0]                                     o_frame_cnt
);

    tx_mode_e              w_mode;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_emit;
    logic [FRAME_BITS-1:0] w_head;
    prbs_step_t            w_prbs;

    lad_t                  r_dat;
    logic                  r_vld;
    logic                  r_uf;
    logic [15:0]           r_uf_cnt;
    logic [15:0]           r_frame_cnt;
    logic [ADC_WIDTH-1:0]  r_base;
    logic [LFSR_WIDTH-1:0] r_lfsr;

    assign w_mode = tx_mode_e'(i_mode);
    assign o_rdy  = !w_full && !i_rst;
    assign w_push = i_vld && o_rdy;
    assign w_pop  = i_en && (w_mode == TX_FIFO) && !w_empty;
    assign w_emit = i_en && ((w_mode != TX_FIFO) || !w_empty);
    assign w_prbs = prbs7_step(r_lfsr);

    dsp_fe_frame_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (w_push),
        .i_wdata (FRAME_BITS'(i_dat)),
        .i_pop   (w_pop),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // Output register: idle unless a frame is emitted this edge.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_dat       <= to_lad(fill_frame(IDLE_CODE));
            r_vld       <= 1'b0;
            r_uf        <= 1'b0;
            r_uf_cnt    <= 16'h0000;
            r_frame_cnt <= 16'h0000;
            r_base      <= '0;
            r_lfsr      <= 7'h7F;
        end else begin
            r_dat <= to_lad(fill_frame(IDLE_CODE));
            r_vld <= w_emit;
            if (w_emit) r_frame_cnt <= r_frame_cnt + 16'd1;
            if (i_en) begin
                case (w_mode)
                    TX_FIFO: begin
                        if (w_empty) begin
                            r_uf <= 1'b1;
                            if (r_uf_cnt != 16'hFFFF) r_uf_cnt <= r_uf_cnt + 16'd1;
                        end else begin
                            r_dat <= to_lad(frame_t'(w_head));
                        end
                    end
                    TX_RAMP: begin
                        r_dat  <= to_lad(ramp_frame(r_base));
                        r_base <= r_base + ADC_WIDTH'(FRAME_SAMPLES);
                    end
                    TX_PRBS7: begin
                        r_dat  <= to_lad(w_prbs.bits);
                        r_lfsr <= w_prbs.state;
                    end
                    TX_CONST: r_dat <= to_lad(fill_frame(i_const));
                    default: ;
                endcase
            end
        end
    end

    assign o_dat_lad       = r_dat;
    assign o_vld           = r_vld;
    assign o_underflow     = r_uf;
    assign o_underflow_cnt = r_uf_cnt;
    assign o_frame_cnt     = r_frame_cnt;

endmodule

// File: tb/tb_dsp_fe_lad_tx.sv
// Self-checking bench for dsp_fe_lad_tx against a queue/bitstream reference model.
module tb_dsp_fe_lad_tx;

    localparam int NS = 32;
    localparam int AW = 6;
    localparam int NL = 16;
    localparam int ND = 2;

    typedef logic [NS-1:0][AW-1:0]         fr_t;
    typedef logic [NL-1:0][AW-1:0][ND-1:0] tlad_t;

    logic        i_clk = 1'b0;
    logic        i_rst;
    fr_t         i_dat;
    logic        i_vld;
    logic        o_rdy;
    logic        i_en;
    logic [1:0]  i_mode;
    logic [5:0]  i_const;
    tlad_t       o_dat_lad;
    logic        o_vld;
    logic        o_underflow;
    logic [15:0] o_underflow_cnt;
    logic [15:0] o_frame_cnt;

    dsp_fe_lad_tx dut (
        .i_clk           (i_clk),
        .i_rst           (i_rst),
        .i_dat           (i_dat),
        .i_vld           (i_vld),
        .o_rdy           (o_rdy),
        .i_en            (i_en),
        .i_mode          (i_mode),
        .i_const         (i_const),
        .o_dat_lad       (o_dat_lad),
        .o_vld           (o_vld),
        .o_underflow     (o_underflow),
        .o_underflow_cnt (o_underflow_cnt),
        .o_frame_cnt     (o_frame_cnt)
    );

    always #5 i_clk = ~i_clk;

    // Reference model state
    fr_t         q[$];
    tlad_t       m_dat;
    logic        m_vld;
    logic        m_uf;
    logic [15:0] m_ufc;
    logic [15:0] m_fc;
    int          m_ramp_n;
    int          m_pos;
    bit          golden[127];
    int          errors = 0;
    int          checks = 0;

    function automatic fr_t fill(input logic [5:0] v);
        fr_t f;
        for (int t = 0; t < NS; t++) f[t] = v;
        return f;
    endfunction

    function automatic tlad_t lad_of(input fr_t f);
        tlad_t r;
        for (int l = 0; l < NL; l++)
            for (int d = 0; d < ND; d++)
                for (int a = 0; a < AW; a++)
                    r[l][a][d] = f[l + NL * d][a];
        return r;
    endfunction

    function automatic logic [5:0] smp(input tlad_t x, input int l, input int d);
        logic [5:0] v;
        for (int a = 0; a < AW; a++) v[a] = x[l][a][d];
        return v;
    endfunction

    task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Advance the model by one clock edge from the currently applied inputs.
    task automatic model_step();
        fr_t f;
        bit  emit;
        bit  push;
        f    = fill(6'h20);
        emit = 1'b0;
        if (i_rst) begin
            q.delete();
            m_uf     = 1'b0;
            m_ufc    = 16'h0;
            m_fc     = 16'h0;
            m_ramp_n = 0;
            m_pos    = 0;
        end else begin
            push = i_vld && (q.size() < 4);
            if (i_en) begin
                if (i_mode == 2'd0) begin
                    if (q.size() > 0) begin
                        f    = q.pop_front();
                        emit = 1'b1;
                    end else begin
                        m_uf = 1'b1;
                        if (m_ufc != 16'hFFFF) m_ufc = m_ufc + 16'd1;
                    end
                end else if (i_mode == 2'd1) begin
                    for (int t = 0; t < NS; t++) f[t] = 6'((32 * m_ramp_n + t) % 64);
                    m_ramp_n++;
                    emit = 1'b1;
                end else if (i_mode == 2'd2) begin
                    for (int t = 0; t < NS; t++)
                        for (int a = 0; a < AW; a++)
                            f[t][a] = golden[(m_pos + 6 * t + a) % 127];
                    m_pos = (m_pos + 192) % 127;
                    emit = 1'b1;
                end else begin
                    f    = fill(i_const);
                    emit = 1'b1;
                end
            end
            if (push) q.push_back(i_dat);
            if (emit) m_fc = m_fc + 16'd1;
        end
        m_vld = emit;
        m_dat = lad_of(f);
    endtask

    task automatic check_all();
        chk("rdy", o_rdy, (!i_rst && q.size() < 4));
        chk("vld", o_vld, m_vld);
        chk("dat", o_dat_lad, m_dat);
        chk("underflow", o_underflow, m_uf);
        chk("underflow_cnt", o_underflow_cnt, m_ufc);
        chk("frame_cnt", o_frame_cnt, m_fc);
    endtask

    task automatic step();
        @(posedge i_clk);
        model_step();
        @(negedge i_clk);
        check_all();
    endtask

    task automatic rand_frame();
        for (int t = 0; t < NS; t++) i_dat[t] = 6'($urandom);
    endtask

    initial begin
        for (int n = 0; n < 7; n++) golden[n] = 1'b1;
        for (int n = 7; n < 127; n++) golden[n] = golden[n-7] ^ golden[n-6];

        i_rst = 1'b1; i_vld = 1'b0; i_en = 1'b0; i_mode = 2'd0; i_const = 6'h00;
        i_dat = '0;
        repeat (2) step();
        chk("lit_reset_dat", o_dat_lad, lad_of(fill(6'h20)));
        chk("lit_reset_rdy", o_rdy, 1'b0);

        // Underflow with nothing buffered
        i_rst = 1'b0; i_en = 1'b1;
        repeat (5) step();
        chk("lit_uf_cnt5", o_underflow_cnt, 16'd5);
        chk("lit_uf_flag", o_underflow, 1'b1);

        // Single frame i_dat[t]=t; emitted one edge after the write
        for (int t = 0; t < NS; t++) i_dat[t] = 6'(t);
        i_vld = 1'b1;
        step();
        chk("lit_nobypass_vld", o_vld, 1'b0);
        i_vld = 1'b0;
        step();
        chk("lit_l3d1", smp(o_dat_lad, 3, 1), 6'd19);
        chk("lit_l15d0", smp(o_dat_lad, 15, 0), 6'd15);
        chk("lit_fcnt1", o_frame_cnt, 16'd1);
        step();

        // Fill FIFO with transmit disabled, then drain
        i_en = 1'b0; i_vld = 1'b1;
        for (int k = 0; k < 5; k++) begin
            rand_frame();
            step();
            if (k == 3) chk("lit_full_rdy", o_rdy, 1'b0);
        end
        i_vld = 1'b0; i_en = 1'b1;
        repeat (6) step();

        // Ramp
        i_mode = 2'd1;
        step();
        chk("lit_ramp0", smp(o_dat_lad, 5, 1), 6'd21);
        step();
        chk("lit_ramp1", smp(o_dat_lad, 5, 1), 6'd53);
        step();
        chk("lit_ramp2", smp(o_dat_lad, 5, 1), 6'd21);

        // PRBS7 from reset over 127 frames
        i_rst = 1'b1;
        step();
        i_rst = 1'b0; i_mode = 2'd2;
        step();
        chk("lit_prbs_s0", smp(o_dat_lad, 0, 0), 6'h3F);
        chk("lit_prbs_s1", smp(o_dat_lad, 1, 0), 6'h01);
        repeat (126) step();

        // Constant
        i_mode = 2'd3; i_const = 6'h2A;
        repeat (3) step();

        // Randomized traffic
        for (int c = 0; c < 2000; c++) begin
            i_rst   = ($urandom_range(0, 99) == 0);
            i_vld   = 1'($urandom);
            i_en    = ($urandom_range(0, 3) != 0);
            i_mode  = ($urandom_range(0, 2) == 0) ? 2'($urandom) : 2'd0;
            i_const = 6'($urandom);
            rand_frame();
            step();
        end

        // Reset with frames buffered
        i_rst = 1'b0; i_en = 1'b0; i_vld = 1'b1; i_mode = 2'd0;
        repeat (3) begin rand_frame(); step(); end
        i_rst = 1'b1;
        repeat (2) step();
        chk("lit_rst_rdy", o_rdy, 1'b0);
        i_rst = 1'b0; i_vld = 1'b0; i_en = 1'b1;
        step();
        chk("lit_rst_empty_vld", o_vld, 1'b0);
        chk("lit_rst_empty_uf", o_underflow_cnt, 16'd1);

        // Saturate the underflow counter
        repeat (65540) step();
        chk("lit_uf_sat", o_underflow_cnt, 16'hFFFF);
        i_rst = 1'b1;
        step();
        chk("lit_uf_cleared", o_underflow_cnt, 16'h0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
